instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer side of the instruction path: fetches 32-bit ARM words from instruction memory
//  over a req/gnt/rvalid handshake, buffers them in a small prefetch FIFO, and presents them
//  to the controller/datapath with a valid/ready handshake. Takes taken-branch/PC-write redirects
//  (the controller's PCSrc and ALU result) and flushes stale fetches. Replaces the bare PC register.
// PARAMETERS
//  DEPTH    4             prefetch FIFO entries; power of 2, >=2; also max requests in flight
//  RESET_PC 32'h0000_0000 first fetch address after reset
// PORTS
//  clk          in  1   single clock, rising edge
//  reset        in  1   asynchronous, active-high
//  imem_req     out 1   fetch request valid
//  imem_addr    out 32  fetch address; bits[1:0] always 0
//  imem_gnt     in  1   request accepted this cycle (req&gnt = issued)
//  imem_rvalid  in  1   read data valid; responses in order, >=1 cycle after grant
//  imem_rdata   in  32  instruction word
//  redirect     in  1   taken branch / PC write; has priority over all other events
//  redirect_pc  in  32  new fetch address; bits[1:0] ignored (forced 0)
//  instr_valid  out 1   instr/instr_pc valid
//  instr        out 32  instruction word to controller Instr[31:0]
//  instr_pc     out 32  address of instr (PC+8 adjustment is not done here)
//  instr_ready  in  1   consumer accepts when instr_valid&instr_ready
//  stat_fetched out 32  words delivered to FIFO (FETCH_STATS_EN only)
//  stat_dropped out 32  responses discarded by flush (FETCH_STATS_EN only)
// BEHAVIOUR
//  Reset (async): state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0; imem_req=0,
//   imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, stats=0.
//  FSM: BOOT -> RUN after one cycle (no request in BOOT).
//   RUN: imem_req=1 iff fifo_count+outstanding < DEPTH (credit); on req&gnt fetch_pc+=4
//    (32-bit wrap 0xFFFF_FFFC -> 0). rvalid pushes {rdata, pc} into FIFO; the push is
//    visible on instr next cycle (no bypass). Overflow impossible by credit rule.
//   RUN & redirect: FIFO cleared, fetch_pc=redirect_pc, imem_req=0 that cycle; if
//    outstanding (incl. a grant or minus an rvalid in the same cycle) is 0 -> RUN, else FLUSH.
//   FLUSH: imem_req=0; every rvalid is discarded; outstanding==0 after update -> RUN.
//    Redirect in FLUSH: fetch_pc updated, stay in FLUSH.
//  outstanding: +1 on req&gnt, -1 on rvalid, both same cycle = unchanged; rvalid with
//   outstanding==0 is a protocol error (assertion, ignored).
//  Pop on instr_valid&instr_ready; redirect same cycle wins (pop void, FIFO cleared).
//  Push and pop same cycle with FIFO full-1/empty handled: count unchanged, order kept.
//  instr_valid deasserts the cycle after redirect; first post-redirect word arrives no
//   earlier than 2 cycles after grant of redirect_pc.
//  Steady state with 1-cycle memory and instr_ready=1: one instruction per cycle.
// CONFIGURATION
//  FETCH_STATS_EN defined: stat_fetched +1 per FIFO push, stat_dropped +1 per FLUSH-discard
//   or per FIFO entry cleared by redirect; both wrap at 2^32, reset to 0.
//  Undefined: counters not built; stat_* ports tied to 0.
// STRUCTURE
//  fetch_pkg: fetch_state_t enum {BOOT, RUN, FLUSH}; typedef instr_t (logic[31:0]);
//   typedef fetch_entry_t struct {instr_t word; logic[31:0] pc}; WORD_BYTES=4.
//  Sub-module fetch_fifo: sync FIFO of fetch_entry_t, DEPTH param, push/pop/clear/count.
// TESTING
//  Reset release, gnt=1, 1-cycle rdata=addr^32'hE000_0000 -> addrs 0,4,8..; instr_pc
//   matches; one instr/cycle after fill.
//  instr_ready=0 for 10 cycles -> exactly DEPTH (4) words buffered, imem_req drops, no loss.
//  Redirect to 0x100 with 3 outstanding -> those 3 rvalids dropped, next instr_pc=0x100,
//   stat_dropped+=3+fifo_count (FETCH_STATS_EN).
//  Redirect and instr_ready same cycle, FIFO holding 2 -> no pop, instr_valid=0 next cycle.
//  redirect_pc=0x0000_0203 -> imem_addr=0x200; fetch from 0xFFFF_FFFC wraps to 0x0.
//  Assert reset mid-FLUSH with gnt pending -> all outputs at reset values same cycle, refetch RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch path.
//   fetch_state_t : fetch sequencer states (BOOT, RUN, FLUSH)
//   instr_t       : one 32-bit instruction word
//   fetch_entry_t : prefetch FIFO entry {word, pc}
//   WORD_BYTES    : fetch stride in bytes
//   align_word()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        instr_t      word;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t. The head entry is read straight
// from storage, so a push becomes visible on head one cycle later.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset (empties the FIFO)
//   clear     in   synchronous flush; wins over push and pop
//   push      in   write push_data (caller guarantees not full)
//   push_data in   entry to write
//   pop       in   drop the head entry (caller guarantees not empty)
//   head      out  oldest entry (undefined content when count == 0)
//   count     out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage needs no reset: validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches 32-bit words from instruction memory (req/gnt/rvalid), buffers them
// in a prefetch FIFO and hands them to the core with valid/ready. A redirect
// (taken branch / PC write) clears the FIFO and discards responses that are
// still in flight.
// Optional feature: define FETCH_STATS_EN to build the fetched/dropped
// counters; otherwise stat_fetched/stat_dropped are tied to 0.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   imem_req/addr           fetch request and word address
//   imem_gnt                request accepted this cycle
//   imem_rvalid/rdata       in-order read response
//   redirect/redirect_pc    new fetch address, highest priority
//   instr_valid/instr/pc    instruction to the consumer
//   instr_ready             consumer accepts
//   stat_fetched/dropped    delivered / discarded word counters
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = DEPTH[CW:0];

    fetch_state_t  state_q;
    logic [31:0]   fetch_pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_valid;
    logic          credit_ok;
    logic          issue;
    logic          rsp_ok;
    logic          push;
    logic          pop;

    assign fifo_valid = (fifo_count != '0);

    // Never have more words buffered plus in flight than the FIFO can hold,
    // so an arriving response always has a free slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_W;

    assign imem_req  = (state_q == RUN) && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = imem_rvalid && (outstanding_q != '0);
    assign push   = rsp_ok && (state_q == RUN) && !redirect;
    assign pop    = fifo_valid && instr_ready && !redirect;

    assign outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_ok);

    // In RUN every outstanding request was issued sequentially since the last
    // redirect, so the oldest one sits outstanding_q words behind fetch_pc_q.
    assign push_entry.word = imem_rdata;
    assign push_entry.pc   = fetch_pc_q - (32'(outstanding_q) << 2);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect) begin
                fetch_pc_q <= align_word(redirect_pc);
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'(WORD_BYTES);
            end
            case (state_q)
                BOOT:  state_q <= RUN;
                RUN:   if (redirect) state_q <= (outstanding_d == '0) ? RUN : FLUSH;
                // A redirect while flushing restarts the wait for quiet.
                FLUSH: if (!redirect && outstanding_d == '0) state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign instr_valid = fifo_valid;
    assign instr       = fifo_valid ? fifo_head.word : '0;
    assign instr_pc    = fifo_valid ? fifo_head.pc   : '0;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_dropped_q;
    logic [31:0] drop_inc;

    // A redirect throws away every buffered word plus any response landing
    // in the same cycle; in FLUSH each response is a discard.
    always_comb begin
        drop_inc = '0;
        if (redirect) begin
            drop_inc = 32'(fifo_count) + 32'(rsp_ok);
        end else if (state_q == FLUSH && rsp_ok) begin
            drop_inc = 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched_q <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_q + 32'(push);
            stat_dropped_q <= stat_dropped_q + drop_inc;
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_dropped = stat_dropped_q;
`else
    assign stat_fetched = '0;
    assign stat_dropped = '0;
`endif

    rvalid_has_request: assert property (
        @(posedge clk) disable iff (reset) !(imem_rvalid && outstanding_q == '0)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench with a memory model (configurable latency, data = addr ^
// 0xE000_0000) and a scoreboard: each granted fetch pushes its expected
// {word, pc}; a redirect empties it. A separate monitor pops and compares on
// every accepted instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .stat_fetched (stat_fetched),
        .stat_dropped (stat_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_item_t;

    exp_t        sb[$];
    mem_item_t   mem_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pop_cnt = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic [31:0] exp_pc;
    logic        req_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        mem_item_t m;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            m           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = m.addr ^ 32'hE000_0000;
        end
        #1;
        req_seen = imem_req;
        if (redirect) begin
            sb.delete();
            exp_pc = redirect_pc & ~32'h3;
        end
        if (imem_req && imem_gnt) begin
            chk("grant_addr", imem_addr, exp_pc);
            mem_q.push_back('{addr: imem_addr, due: cyc + lat});
            sb.push_back('{word: exp_pc ^ 32'hE000_0000, pc: exp_pc});
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_stat(input string name, input logic [31:0] act, input logic [31:0] expv);
`ifdef FETCH_STATS_EN
        chk(name, act, expv);
`else
        chk(name, act, 32'd0);
`endif
    endtask

    // Monitor: compares each accepted instruction against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (instr_valid && instr_ready && !redirect) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h word %h, expected none", instr_pc, instr);
                end else begin
                    e = sb.pop_front();
                    chk("instr_word", instr, e.word);
                    chk("instr_pc", instr_pc, e.pc);
                end
            end
        end
    end

    initial begin
        int valid_cnt;
        int pops0;
        logic [31:0] drop0;

        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        exp_pc      = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fetched", stat_fetched, 32'd0);
        chk("rst_dropped", stat_dropped, 32'd0);

        // Streaming with 1-cycle memory: one instruction per cycle after fill
        reset       = 1'b0;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        lat         = 1;
        valid_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) chk("boot_no_req", {31'd0, imem_req}, 32'd0);
            if (i >= 3 && instr_valid) valid_cnt++;
            cycle();
        end
        chk("stream_valid_cycles", valid_cnt, 32'd17);
        chk_stat("stream_fetched", stat_fetched, 32'd18);

        // Consumer stall: FIFO fills to DEPTH, requests stop, nothing lost
        instr_ready = 1'b0;
        run(10);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("stall_req_dropped", {31'd0, imem_req}, 32'd0);
        imem_gnt    = 1'b0;
        instr_ready = 1'b1;
        pops0       = pop_cnt;
        run(8);
        chk("stall_buffered_words", pop_cnt - pops0, 32'd4);
        chk("stall_drained", {31'd0, instr_valid}, 32'd0);

        // Redirect to 0x100 with one buffered word and 3 outstanding
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        run(1);
        imem_gnt = 1'b0;
        run(3);
        lat      = 6;
        imem_gnt = 1'b1;
        run(3);
        imem_gnt = 1'b0;
        chk("credit_full_no_req", {31'd0, imem_req}, 32'd0);
        drop0       = stat_dropped;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        run(1);
        redirect = 1'b0;
        chk("redir_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        lat         = 1;
        pops0       = pop_cnt;
        run(12);
        chk("redir_pops", pop_cnt - pops0, 32'd5);
        chk_stat("redir_dropped", stat_dropped - drop0, 32'd4);

        // Redirect together with instr_ready while 2 words are buffered
        imem_gnt = 1'b0;
        run(6);
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        run(2);
        imem_gnt = 1'b0;
        run(3);
        chk("two_buffered_valid", {31'd0, instr_valid}, 32'd1);
        pops0       = pop_cnt;
        drop0       = stat_dropped;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        run(1);
        redirect = 1'b0;
        chk("redir_cycle_no_req", {31'd0, req_seen}, 32'd0);
        chk("redir_ready_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("redir_aligned_addr", imem_addr, 32'h0000_0200);
        chk("redir_pop_void", pop_cnt - pops0, 32'd0);
        chk_stat("redir2_dropped", stat_dropped - drop0, 32'd2);
        imem_gnt = 1'b1;
        run(8);

        // Fetch across the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        run(1);
        redirect = 1'b0;
        run(10);

        // Reset asserted mid-FLUSH with a grant pending
        lat = 5;
        run(4);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        run(1);
        redirect = 1'b0;
        chk("flush_no_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_pc", instr_pc, 32'd0);
        chk("mid_rst_fetched", stat_fetched, 32'd0);
        chk("mid_rst_dropped", stat_dropped, 32'd0);
        mem_q.delete();
        sb.delete();
        exp_pc = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        lat   = 1;
        pops0 = pop_cnt;
        run(10);
        chk("refetch_pops", pop_cnt - pops0, 32'd7);

        // Drain everything still expected
        imem_gnt = 1'b0;
        run(6);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
